// File: rtl/rv32_pkg.sv
// rv32_pkg: shared register-file widths and the write-back entry record
package rv32_pkg;
    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back entries; pointers carry an extra wrap bit
module wb_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  wb_entry din,
    output wb_entry dout,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);
    wb_entry       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];
    // pointer advance and storage write; push is ignored when full, pop when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: single register-file write port shared by ALU and buffered loads, plus RAW scoreboard (optional bypass: WB_BYPASS_EN)
module rf_wb_arbiter
    import rv32_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_alu_valid,
    input  logic [REG_AW-1:0] i_alu_rd,
    input  logic [XLEN-1:0]   i_alu_data,
    output logic              o_alu_ready,
    input  logic              i_ld_valid,
    input  logic [REG_AW-1:0] i_ld_rd,
    input  logic [XLEN-1:0]   i_ld_data,
    output logic              o_ld_ready,
    input  logic              i_issue_valid,
    input  logic [REG_AW-1:0] i_issue_rd,
    input  logic [REG_AW-1:0] i_RA1,
    input  logic [REG_AW-1:0] i_RA2,
    output logic              o_busy1,
    output logic              o_busy2,
    output logic [REG_AW-1:0] o_WA,
    output logic [XLEN-1:0]   o_WD,
    output logic              o_WE,
    output logic              o_fwd1,
    output logic              o_fwd2,
    output logic [XLEN-1:0]   o_fwd_data
);
    wb_entry     head;
    wb_entry     win;
    logic        full;
    logic        empty;
    logic        pop;
    logic        win_valid;
    logic [31:0] busy;
    logic [31:0] busy_nxt;

    wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (i_ld_valid && !full),
        .pop   (pop),
        .din   ('{rd: i_ld_rd, data: i_ld_data}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign o_alu_ready = !full;
    assign o_ld_ready  = !full;
    assign pop         = full || (!i_alu_valid && !empty);
    assign win_valid   = pop || i_alu_valid;
    assign win         = pop ? head : '{rd: i_alu_rd, data: i_alu_data};

    // register the winner; x0 results are consumed but never raise the write enable
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_WE <= 1'b0;
            o_WA <= '0;
            o_WD <= '0;
        end else begin
            o_WE <= win_valid && (win.rd != '0);
            if (win_valid) begin
                o_WA <= win.rd;
                o_WD <= win.data;
            end
        end
    end

    // scoreboard update: commit clears, issue sets afterwards so a same-cycle set wins
    always_comb begin
        busy_nxt = busy;
        if (o_WE) busy_nxt[o_WA] = 1'b0;
        if (i_issue_valid) busy_nxt[i_issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // scoreboard state
    always_ff @(posedge i_clk) begin
        if (i_rst) busy <= '0;
        else       busy <= busy_nxt;
    end

`ifdef WB_BYPASS_EN
    assign o_fwd1     = o_WE && (o_WA == i_RA1) && (i_RA1 != '0);
    assign o_fwd2     = o_WE && (o_WA == i_RA2) && (i_RA2 != '0);
    assign o_fwd_data = o_WD;
`else
    assign o_fwd1     = 1'b0;
    assign o_fwd2     = 1'b0;
    assign o_fwd_data = '0;
`endif

    assign o_busy1 = busy[i_RA1] && !o_fwd1;
    assign o_busy2 = busy[i_RA2] && !o_fwd2;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table plus reset-mid-operation sequence for rf_wb_arbiter
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        busy1;
    logic        busy2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic        fwd1;
    logic        fwd2;
    logic [31:0] fwd_data;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        bit        av;
        bit [4:0]  ar;
        bit [31:0] ad;
        bit        lv;
        bit [4:0]  lr;
        bit [31:0] ld;
        bit        iv;
        bit [4:0]  ir;
        bit [4:0]  r1;
        bit [4:0]  r2;
        bit        e_ardy;
        bit        e_lrdy;
        bit        e_we;
        bit [4:0]  e_wa;
        bit [31:0] e_wd;
        bit        e_b1;
        bit        e_b2;
    } vec_t;

    vec_t vecs [25];

    rf_wb_arbiter #(.LQ_DEPTH(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alu_valid   (alu_valid),
        .i_alu_rd      (alu_rd),
        .i_alu_data    (alu_data),
        .o_alu_ready   (alu_ready),
        .i_ld_valid    (ld_valid),
        .i_ld_rd       (ld_rd),
        .i_ld_data     (ld_data),
        .o_ld_ready    (ld_ready),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_RA1         (ra1),
        .i_RA2         (ra2),
        .o_busy1       (busy1),
        .o_busy2       (busy2),
        .o_WA          (wa),
        .o_WD          (wd),
        .o_WE          (we),
        .o_fwd1        (fwd1),
        .o_fwd2        (fwd2),
        .o_fwd_data    (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit av, input bit [4:0] ar, input bit [31:0] ad,
                         input bit lv, input bit [4:0] lr, input bit [31:0] ldat,
                         input bit iv, input bit [4:0] ir, input bit [4:0] r1, input bit [4:0] r2);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_data = ldat;
        issue_valid = iv; issue_rd = ir; ra1 = r1; ra2 = r2;
    endtask

    initial begin
        //          av    ar     ad          lv    lr     ld          iv    ir     r1     r2     ardy  lrdy  we    wa     wd          b1    b2
        vecs[0]  = '{1'b1, 5'd5,  32'h1234,  1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd5,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,     1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd5,  32'h1234,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFF,  1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd5,  32'h1234,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'hFFFF,  1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd10, 32'hA0,    1'b1, 5'd1,  32'h1001,  1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'hFFFF,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd11, 32'hA1,    1'b1, 5'd2,  32'h1002,  1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd10, 32'hA0,    1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5'd12, 32'hA2,    1'b1, 5'd3,  32'h1003,  1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd11, 32'hA1,    1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'd13, 32'hA3,    1'b1, 5'd4,  32'h1004,  1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd12, 32'hA2,    1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'd14, 32'hA4,    1'b1, 5'd5,  32'hDEAD,  1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd13, 32'hA3,    1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'd14, 32'hA4,    1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd1,  32'h1001,  1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd14, 32'hA4,    1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd2,  32'h1002,  1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd3,  32'h1003,  1'b0, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd4,  32'h1004,  1'b0, 1'b0};
        vecs[14] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b1, 5'd7,  5'd7,  5'd4,  1'b1, 1'b1, 1'b0, 5'd4,  32'h1004,  1'b0, 1'b0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,     1'b1, 5'd7,  32'h77,    1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b0, 5'd4,  32'h1004,  1'b1, 1'b0};
        vecs[16] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b0, 5'd4,  32'h1004,  1'b1, 1'b0};
        vecs[17] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 5'd7,  32'h77,    1'b1, 1'b0};
        vecs[18] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b1, 5'd7,  5'd7,  5'd0,  1'b1, 1'b1, 1'b0, 5'd7,  32'h77,    1'b0, 1'b0};
        vecs[19] = '{1'b0, 5'd0,  32'h0,     1'b1, 5'd7,  32'h99,    1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b0, 5'd7,  32'h77,    1'b1, 1'b0};
        vecs[20] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b0, 5'd7,  32'h77,    1'b1, 1'b0};
        vecs[21] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b1, 5'd7,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 5'd7,  32'h99,    1'b1, 1'b0};
        vecs[22] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 5'd7,  32'h99,    1'b1, 1'b1};
        vecs[23] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd7,  32'h99,    1'b0, 1'b0};
        vecs[24] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd7,  1'b1, 1'b1, 1'b0, 5'd7,  32'h99,    1'b0, 1'b1};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd31);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_we", 32'(we), 32'(1'b0));
        chk("reset_wa", 32'(wa), 32'(5'd0));
        chk("reset_wd", wd, 32'h0);
        chk("reset_ld_ready", 32'(ld_ready), 32'(1'b1));
        chk("reset_alu_ready", 32'(alu_ready), 32'(1'b1));
        chk("reset_busy1", 32'(busy1), 32'(1'b0));
        chk("reset_busy2", 32'(busy2), 32'(1'b0));
        @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].lv, vecs[i].lr, vecs[i].ld,
                  vecs[i].iv, vecs[i].ir, vecs[i].r1, vecs[i].r2);
            @(negedge clk);
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ardy));
            chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(vecs[i].e_lrdy));
            chk($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_wa", i), 32'(wa), 32'(vecs[i].e_wa));
            chk($sformatf("v%0d_wd", i), wd, vecs[i].e_wd);
            chk($sformatf("v%0d_busy1", i), 32'(busy1), 32'(vecs[i].e_b1));
            chk($sformatf("v%0d_busy2", i), 32'(busy2), 32'(vecs[i].e_b2));
`ifndef WB_BYPASS_EN
            chk($sformatf("v%0d_fwd", i), {fwd_data[29:0], fwd1, fwd2}, 32'h0);
`endif
            @(posedge clk);
            #1;
        end

        // reset with three loads queued behind an ALU stream and two busy bits set
        drive(1, 5'd20, 32'h20, 1, 5'd21, 32'h21, 1, 5'd8, 5'd8, 5'd9);
        @(posedge clk);
        #1 drive(1, 5'd22, 32'h22, 1, 5'd23, 32'h23, 1, 5'd9, 5'd8, 5'd9);
        @(posedge clk);
        #1 drive(1, 5'd24, 32'h24, 1, 5'd25, 32'h25, 0, 5'd0, 5'd8, 5'd9);
        @(negedge clk);
        chk("pre_rst_busy1", 32'(busy1), 32'(1'b1));
        chk("pre_rst_busy2", 32'(busy2), 32'(1'b1));
        chk("pre_rst_ld_ready", 32'(ld_ready), 32'(1'b1));
        @(posedge clk);
        #1 drive(1, 5'd26, 32'h26, 0, 5'd0, 32'h0, 0, 5'd0, 5'd8, 5'd9);
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_we", 32'(we), 32'(1'b1));
        chk("pre_rst_wa", 32'(wa), 32'(5'd24));
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd9);
        @(negedge clk);
        chk("post_rst_we", 32'(we), 32'(1'b0));
        chk("post_rst_wa", 32'(wa), 32'(5'd0));
        chk("post_rst_wd", wd, 32'h0);
        chk("post_rst_ld_ready", 32'(ld_ready), 32'(1'b1));
        chk("post_rst_busy1", 32'(busy1), 32'(1'b0));
        chk("post_rst_busy2", 32'(busy2), 32'(1'b0));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd8);
            @(negedge clk);
            chk($sformatf("drain%0d_we", k), 32'(we), 32'(1'b0));
            chk($sformatf("drain%0d_busy1", k), 32'(busy1), 32'(1'b0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
